// File: rtl/session_transport_if.sv
// Session<->transport interface bundle. The session and link side drive the
// master modport; the transport block sits on the slave modport.
interface session_transport_if;
  logic [1:0]  cmd;
  logic [15:0] dataIn;
  logic        transportBusy;
  logic [1:0]  cmdOut;
  logic [15:0] packetOut;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  rx_err_count;

  modport master (
    output cmd, dataIn, tx_ready, rx_data, rx_valid,
    input  transportBusy, cmdOut, packetOut, tx_data, tx_valid, rx_err_count
  );

  modport slave (
    input  cmd, dataIn, tx_ready, rx_data, rx_valid,
    output transportBusy, cmdOut, packetOut, tx_data, tx_valid, rx_err_count
  );
endinterface

// File: rtl/session_transport.sv
// Transport end of the session link: frames session words into 4-byte link
// frames (HDR, HI, LO, CHK) and deframes received link bytes back into
// session words. TX and RX run independently.
module session_transport #(
  parameter int unsigned RX_TIMEOUT = 16,
  parameter logic [3:0]  SOF        = 4'hA
) (
  input  logic               clk,
  input  logic               reset,
  session_transport_if.slave bus
);

  localparam int unsigned GAP_W = $clog2(RX_TIMEOUT + 1);

  typedef enum logic [2:0] {TX_IDLE, TX_HDR, TX_HI, TX_LO, TX_CHK} tx_state_e;
  typedef enum logic [1:0] {RX_HUNT, RX_GOT_HDR, RX_GOT_HI, RX_GOT_LO} rx_state_e;

  tx_state_e        tx_state_q;
  logic [7:0]       tx_hdr_q;
  logic [15:0]      tx_word_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;

  rx_state_e        rx_state_q;
  logic [GAP_W-1:0] rx_gap_q;
  logic [7:0]       rx_hdr_q;
  logic [7:0]       rx_hi_q;
  logic [7:0]       rx_lo_q;
  logic [1:0]       cmd_out_q;
  logic [15:0]      packet_q;
  logic [7:0]       err_q;

  logic             hdr_ok_d;
  logic             chk_ok_d;
  logic             gap_expire_d;
  logic [7:0]       err_d;

  // Header recognition, checksum match, gap expiry and saturated error increment
  always_comb begin
    hdr_ok_d     = (bus.rx_data[7:4] == SOF) && (bus.rx_data[3:2] == 2'b00) &&
                   ((bus.rx_data[1:0] == 2'b01) || (bus.rx_data[1:0] == 2'b10));
    chk_ok_d     = ((rx_hdr_q ^ rx_hi_q ^ rx_lo_q) == bus.rx_data);
    gap_expire_d = (rx_gap_q == GAP_W'(RX_TIMEOUT - 1));
    err_d        = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  end

  // TX framer: each byte held until tx_ready, next byte follows with no gap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_hdr_q   <= '0;
      tx_word_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (bus.cmd == 2'b01 || bus.cmd == 2'b10) begin
            tx_hdr_q   <= {SOF, 2'b00, bus.cmd};
            tx_word_q  <= bus.dataIn;
            tx_data_q  <= {SOF, 2'b00, bus.cmd};
            tx_valid_q <= 1'b1;
            tx_state_q <= TX_HDR;
          end
        end
        TX_HDR: if (bus.tx_ready) begin
          tx_data_q  <= tx_word_q[15:8];
          tx_state_q <= TX_HI;
        end
        TX_HI: if (bus.tx_ready) begin
          tx_data_q  <= tx_word_q[7:0];
          tx_state_q <= TX_LO;
        end
        TX_LO: if (bus.tx_ready) begin
          tx_data_q  <= tx_hdr_q ^ tx_word_q[15:8] ^ tx_word_q[7:0];
          tx_state_q <= TX_CHK;
        end
        TX_CHK: if (bus.tx_ready) begin
          tx_data_q  <= '0;
          tx_valid_q <= 1'b0;
          tx_state_q <= TX_IDLE;
        end
        default: begin
          tx_valid_q <= 1'b0;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  // RX deframer: mid-frame bytes are always payload; resync only via CHK or gap timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_HUNT;
      rx_gap_q   <= '0;
      rx_hdr_q   <= '0;
      rx_hi_q    <= '0;
      rx_lo_q    <= '0;
      cmd_out_q  <= 2'b00;
      packet_q   <= '0;
      err_q      <= '0;
    end else begin
      cmd_out_q <= 2'b00;
      if (rx_state_q == RX_HUNT) begin
        rx_gap_q <= '0;
        if (bus.rx_valid && hdr_ok_d) begin
          rx_hdr_q   <= bus.rx_data;
          rx_state_q <= RX_GOT_HDR;
        end
      end else if (bus.rx_valid) begin
        rx_gap_q <= '0;
        case (rx_state_q)
          RX_GOT_HDR: begin
            rx_hi_q    <= bus.rx_data;
            rx_state_q <= RX_GOT_HI;
          end
          RX_GOT_HI: begin
            rx_lo_q    <= bus.rx_data;
            rx_state_q <= RX_GOT_LO;
          end
          RX_GOT_LO: begin
            if (chk_ok_d) begin
              cmd_out_q <= rx_hdr_q[1:0];
              packet_q  <= {rx_hi_q, rx_lo_q};
            end else begin
              err_q <= err_d;
            end
            rx_state_q <= RX_HUNT;
          end
          default: rx_state_q <= RX_HUNT;
        endcase
      end else if (gap_expire_d) begin
        err_q      <= err_d;
        rx_gap_q   <= '0;
        rx_state_q <= RX_HUNT;
      end else begin
        rx_gap_q <= rx_gap_q + 1'b1;
      end
    end
  end

  assign bus.tx_data       = tx_data_q;
  assign bus.tx_valid      = tx_valid_q;
  assign bus.transportBusy = tx_valid_q;
  assign bus.cmdOut        = cmd_out_q;
  assign bus.packetOut     = packet_q;
  assign bus.rx_err_count  = err_q;

endmodule

// File: tb/tb_session_transport.sv
// Bench for session_transport: directed scenarios plus a randomized phase,
// all checked every cycle against a queue-based reference model.
module tb_session_transport;
  localparam int unsigned RX_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  session_transport_if bus();

  session_transport #(.RX_TIMEOUT(RX_TIMEOUT), .SOF(4'hA)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: TX is a queue of bytes still to go out (head = byte on
  // the wire); RX is the list of bytes collected for the current frame.
  logic [7:0]  m_txq[$];
  logic [7:0]  m_rxq[$];
  int unsigned m_gap;
  logic [1:0]  m_cmd;
  logic [15:0] m_pkt;
  int unsigned m_err;
  logic [7:0]  dut_seen[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_txq.delete();
    m_rxq.delete();
    m_gap = 0;
    m_cmd = 2'b00;
    m_pkt = '0;
    m_err = 0;
  endtask

  task automatic model_edge();
    logic [7:0] h;
    logic [7:0] b0;
    // TX
    if (m_txq.size() != 0) begin
      if (bus.tx_ready) void'(m_txq.pop_front());
    end else if (bus.cmd == 2'b01 || bus.cmd == 2'b10) begin
      h = {4'hA, 2'b00, bus.cmd};
      m_txq.push_back(h);
      m_txq.push_back(bus.dataIn[15:8]);
      m_txq.push_back(bus.dataIn[7:0]);
      m_txq.push_back(h ^ bus.dataIn[15:8] ^ bus.dataIn[7:0]);
    end
    // RX
    m_cmd = 2'b00;
    if (m_rxq.size() == 0) begin
      if (bus.rx_valid && bus.rx_data[7:4] == 4'hA && bus.rx_data[3:2] == 2'b00 &&
          (bus.rx_data[1:0] == 2'b01 || bus.rx_data[1:0] == 2'b10)) begin
        m_rxq.push_back(bus.rx_data);
        m_gap = 0;
      end
    end else if (bus.rx_valid) begin
      m_rxq.push_back(bus.rx_data);
      m_gap = 0;
      if (m_rxq.size() == 4) begin
        if ((m_rxq[0] ^ m_rxq[1] ^ m_rxq[2]) == m_rxq[3]) begin
          b0    = m_rxq[0];
          m_cmd = b0[1:0];
          m_pkt = {m_rxq[1], m_rxq[2]};
        end else if (m_err < 255) begin
          m_err++;
        end
        m_rxq.delete();
      end
    end else begin
      m_gap++;
      if (m_gap == RX_TIMEOUT) begin
        if (m_err < 255) m_err++;
        m_rxq.delete();
        m_gap = 0;
      end
    end
  endtask

  task automatic check_all();
    check("tx_valid", bus.tx_valid, m_txq.size() != 0);
    check("transportBusy", bus.transportBusy, m_txq.size() != 0);
    if (m_txq.size() != 0) check("tx_data", bus.tx_data, m_txq[0]);
    check("cmdOut", bus.cmdOut, m_cmd);
    check("packetOut", bus.packetOut, m_pkt);
    check("rx_err_count", bus.rx_err_count, m_err);
  endtask

  task automatic step();
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) dut_seen.push_back(bus.tx_data);
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int unsigned n);
    bus.rx_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_seen(input string tag, input logic [31:0] exp_bytes);
    check({tag, "_count"}, dut_seen.size(), 4);
    for (int unsigned i = 0; i < 4; i++)
      if (i < dut_seen.size())
        check(tag, dut_seen[i], exp_bytes[31 - 8*i -: 8]);
  endtask

  initial begin
    int unsigned busy_n;
    int unsigned hold;
    int unsigned r;
    logic [7:0]  pend[$];
    logic [1:0]  t;
    logic [15:0] d;
    logic [7:0]  h;

    reset        = 1'b0;
    bus.cmd      = 2'b00;
    bus.dataIn   = '0;
    bus.tx_ready = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    model_reset();
    #2;
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_busy", bus.transportBusy, 0);
    check("rst_cmdOut", bus.cmdOut, 0);
    check("rst_packetOut", bus.packetOut, 0);
    check("rst_err", bus.rx_err_count, 0);
    step();
    step();
    reset = 1'b1;
    step();

    // Plain TX frame, ready always high; dataIn changes after accept are ignored
    dut_seen.delete();
    bus.tx_ready = 1'b1;
    bus.cmd      = 2'b10;
    bus.dataIn   = 16'h1234;
    step();
    bus.cmd    = 2'b00;
    bus.dataIn = 16'hFFFF;
    busy_n     = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      step();
      if (i < 4) check("tx1_busy_run", bus.transportBusy, (i < 3) ? 1 : 0);
      if (bus.transportBusy === 1'b1) busy_n++;
    end
    check_seen("tx1_bytes", 32'hA2123484);
    check("tx1_busy_cycles", busy_n, 3);

    // TX with stall during HI and a cmd pulse while busy
    dut_seen.delete();
    bus.cmd    = 2'b01;
    bus.dataIn = 16'h0501;
    step();
    bus.cmd = 2'b00;
    step();
    bus.tx_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      bus.cmd    = (i == 2) ? 2'b10 : 2'b00;
      bus.dataIn = 16'($urandom);
      step();
      check("tx2_hi_held", bus.tx_data, 8'h05);
    end
    bus.cmd      = 2'b00;
    bus.tx_ready = 1'b1;
    for (int unsigned i = 0; i < 5; i++) step();
    check_seen("tx2_bytes", 32'hA10501A5);
    check("tx2_no_queued", bus.tx_valid, 0);

    // RX good frame with idle gaps
    bus.tx_ready = 1'b0;
    rx_byte(8'hA2); idle(2);
    rx_byte(8'hBE); idle(1);
    rx_byte(8'hEF); idle(3);
    rx_byte(8'hF3);
    check("rx1_cmd", bus.cmdOut, 2'b10);
    check("rx1_pkt", bus.packetOut, 16'hBEEF);
    idle(1);
    check("rx1_cmd_end", bus.cmdOut, 2'b00);
    check("rx1_pkt_held", bus.packetOut, 16'hBEEF);

    // RX bad checksum, then a good frame
    rx_byte(8'hA1); rx_byte(8'h00); rx_byte(8'h01); rx_byte(8'h00);
    check("rx2_no_cmd", bus.cmdOut, 2'b00);
    check("rx2_err", bus.rx_err_count, 1);
    check("rx2_pkt_kept", bus.packetOut, 16'hBEEF);
    rx_byte(8'hA1); rx_byte(8'h12); rx_byte(8'h34); rx_byte(8'h87);
    check("rx3_cmd", bus.cmdOut, 2'b01);
    check("rx3_pkt", bus.packetOut, 16'h1234);

    // Gap timeout boundary, junk in HUNT, and recovery
    rx_byte(8'hA2); rx_byte(8'h11);
    idle(RX_TIMEOUT - 1);
    check("to_not_yet", bus.rx_err_count, 1);
    idle(1);
    check("to_err", bus.rx_err_count, 2);
    rx_byte(8'h55); rx_byte(8'hA3);
    rx_byte(8'hA2); rx_byte(8'hBE); rx_byte(8'hEF); rx_byte(8'hF3);
    check("to_recover_cmd", bus.cmdOut, 2'b10);
    check("to_recover_err", bus.rx_err_count, 2);
    rx_byte(8'hA2);
    idle(RX_TIMEOUT - 1);
    rx_byte(8'hBE); rx_byte(8'hEF); rx_byte(8'hF3);
    check("gap_edge_cmd", bus.cmdOut, 2'b10);
    check("gap_edge_err", bus.rx_err_count, 2);

    // Good RX frame completing in the same cycle as a TX accept
    rx_byte(8'hA1); rx_byte(8'h12); rx_byte(8'h34);
    bus.cmd      = 2'b10;
    bus.dataIn   = 16'h5AA5;
    bus.tx_ready = 1'b1;
    rx_byte(8'h87);
    bus.cmd = 2'b00;
    check("sim_rx_cmd", bus.cmdOut, 2'b01);
    check("sim_tx_valid", bus.tx_valid, 1);
    idle(6);

    // Randomized traffic on both directions
    hold = 0;
    for (int unsigned c = 0; c < 1500; c++) begin
      bus.cmd      = ($urandom_range(0, 9) < 4) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.dataIn   = 16'($urandom);
      bus.tx_ready = ($urandom_range(0, 3) != 0);
      if (pend.size() == 0 && hold == 0) begin
        r = $urandom_range(0, 9);
        t = 2'($urandom_range(1, 2));
        d = 16'($urandom);
        h = {4'hA, 2'b00, t};
        if (r < 7) begin
          pend.push_back(h);
          pend.push_back(d[15:8]);
          pend.push_back(d[7:0]);
          if (r < 5) pend.push_back(h ^ d[15:8] ^ d[7:0]);
          else if (r == 5) pend.push_back(h ^ d[15:8] ^ d[7:0] ^ 8'(1 << $urandom_range(0, 7)));
        end else if (r == 7) begin
          pend.push_back(8'($urandom));
        end else begin
          hold = $urandom_range(0, RX_TIMEOUT + 4);
        end
      end
      if (hold != 0) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        hold--;
      end else if (pend.size() != 0 && $urandom_range(0, 3) != 0) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = pend.pop_front();
      end else begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
      end
      step();
    end
    bus.cmd      = 2'b00;
    bus.tx_ready = 1'b1;
    idle(RX_TIMEOUT + 2);

    // Error counter saturation
    bus.tx_ready = 1'b0;
    for (int unsigned i = 0; i < 260; i++) begin
      rx_byte(8'hA1); rx_byte(8'h00); rx_byte(8'h00); rx_byte(8'h00);
    end
    check("err_saturated", bus.rx_err_count, 255);

    // Asynchronous reset mid TX HI byte and mid RX frame
    bus.tx_ready = 1'b1;
    bus.cmd      = 2'b10;
    bus.dataIn   = 16'hABCD;
    rx_byte(8'hA1);
    bus.cmd = 2'b00;
    rx_byte(8'h12);
    bus.tx_ready = 1'b0;
    check("pre_rst_hi", bus.tx_data, 8'hAB);
    #2;
    reset = 1'b0;
    #1;
    check("arst_tx_valid", bus.tx_valid, 0);
    check("arst_busy", bus.transportBusy, 0);
    check("arst_cmdOut", bus.cmdOut, 0);
    check("arst_err", bus.rx_err_count, 0);
    model_reset();
    step();
    step();
    reset = 1'b1;
    step();
    dut_seen.delete();
    bus.tx_ready = 1'b1;
    bus.cmd      = 2'b10;
    bus.dataIn   = 16'h4321;
    step();
    bus.cmd = 2'b00;
    idle(6);
    check_seen("post_rst_tx", 32'hA24321C0);
    rx_byte(8'hA2); rx_byte(8'hBE); rx_byte(8'hEF); rx_byte(8'hF3);
    check("post_rst_rx_cmd", bus.cmdOut, 2'b10);
    check("post_rst_rx_pkt", bus.packetOut, 16'hBEEF);
    check("post_rst_err", bus.rx_err_count, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
